// File: rtl/slave_port_pkg.sv
// Shared serial-bus definitions: port FSM states and counter sizing,
// common to the slave port and the master-side port.
package slave_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RREQ,
    RWAIT,
    RDATA
  } port_state_t;

  // Bit counter must index the wider of the address and data fields.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/slave_port_serial_shift_reg.sv
// Right-shifting register with parallel load; serial data enters at the MSB
// so an LSB-first stream lands in natural bit order after WIDTH shifts.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             shift,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/slave_port.sv
// Serial-bus slave port: deserialises address/write data into memory strobes
// and serialises memory read data back onto the bus, LSB first.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  smvalid,
  output logic                  srdata,
  output logic                  ssvalid,
  output logic                  sready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  port_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  addr_shift;
  logic                  data_load;
  logic                  data_shift;
  logic                  data_sin;

  // The data register captures write data and, on reads, is reloaded from
  // memory and shifted out; wdata_r keeps mem_wdata stable across reads.
  always_comb begin
    addr_shift = smvalid && (state == IDLE || state == ADDR);
    data_load  = (state == RWAIT);
    data_shift = (smvalid && state == WDATA) || (state == RDATA);
    data_sin   = (state == WDATA) ? swdata : 1'b0;
  end

  serial_shift_reg #(.WIDTH(ADDR_WIDTH)) addr_sr (
    .clk   (clk),
    .rstn  (rstn),
    .load  (1'b0),
    .din   ('0),
    .shift (addr_shift),
    .sin   (swdata),
    .q     (addr_q)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) data_sr (
    .clk   (clk),
    .rstn  (rstn),
    .load  (data_load),
    .din   (mem_rdata),
    .shift (data_shift),
    .sin   (data_sin),
    .q     (data_q)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      mode    <= 1'b0;
      wdata_r <= '0;
    end else begin
      unique case (state)
        IDLE: if (smvalid) begin
          mode  <= smode;
          cnt   <= CNT_W'(1);
          state <= ADDR;
        end
        ADDR: if (smvalid) begin
          if (cnt == ADDR_LAST) begin
            cnt   <= '0;
            state <= mode ? WDATA : RREQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WDATA: if (smvalid) begin
          if (cnt == DATA_LAST) begin
            cnt     <= '0;
            wdata_r <= {swdata, data_q[DATA_WIDTH-1:1]};
            state   <= WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: state <= IDLE;
        RREQ:  state <= RWAIT;
        RWAIT: state <= RDATA;
        RDATA: begin
          if (cnt == DATA_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    sready    = rstn && (state == IDLE);
    mem_wen   = rstn && (state == WRITE);
    mem_ren   = rstn && (state == RREQ);
    ssvalid   = rstn && (state == RDATA);
    srdata    = ssvalid && data_q[0];
    mem_addr  = rstn ? addr_q : '0;
    mem_wdata = rstn ? wdata_r : '0;
  end

endmodule

// File: tb/tb_slave_port.sv
// Directed and random bus transactions against a reference memory image.
module tb_slave_port;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          swdata;
  logic          smode;
  logic          smvalid;
  logic          srdata;
  logic          ssvalid;
  logic          sready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wen;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;

  slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .swdata    (swdata),
    .smode     (smode),
    .smvalid   (smvalid),
    .srdata    (srdata),
    .ssvalid   (ssvalid),
    .sready    (sready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wen_cnt = 0;
  int ren_cnt = 0;
  int low_seen = 0;

  logic [DW-1:0] bus_mem [0:(1<<AW)-1];
  bit            bus_valid [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == 12'h001) ? 8'h81 : (a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3D);
  endfunction

  // Memory attached to the port: data one cycle after mem_ren, junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wen === 1'b1) begin
      bus_mem[mem_addr]   <= mem_wdata;
      bus_valid[mem_addr] <= 1'b1;
      wen_cnt <= wen_cnt + 1;
    end
    if (mem_ren === 1'b1) begin
      ren_cnt   <= ren_cnt + 1;
      mem_rdata <= bus_valid[mem_addr] ? bus_mem[mem_addr] : init_val(mem_addr);
    end else begin
      mem_rdata <= DW'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (sready === 1'b0) low_seen++;
  endtask

  task automatic drive(input bit v, input bit d, input bit m);
    smvalid = v;
    swdata  = d;
    smode   = m;
  endtask

  // One complete transaction; stalls insert smvalid=0 cycles, hold keeps
  // smvalid high with junk once the port stops listening.
  task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int astall_after, input int astall_n,
                     input int dstall_before, input int dstall_n,
                     input bit hold, output int span, output logic [DW-1:0] got);
    int waited;
    int wen0;
    int ren0;
    int t0;
    waited = 0;
    span = 0;
    got = '0;
    t0 = 0;
    while (sready !== 1'b1 && waited < 200) begin
      drive(1'b0, 1'b0, 1'b0);
      step();
      waited++;
    end
    if (sready !== 1'b1) begin
      check("ready_timeout", {31'b0, sready}, 32'd1);
      return;
    end
    wen0 = wen_cnt;
    ren0 = ren_cnt;
    low_seen = 0;
    for (int i = 0; i < AW; i++) begin
      drive(1'b1, a[i], wr);
      step();
      if (i == 0) t0 = cyc;
      if (i == astall_after) begin
        repeat (astall_n) begin
          drive(1'b0, 1'($urandom), 1'($urandom));
          step();
        end
      end
    end
    if (wr) begin
      for (int i = 0; i < DW; i++) begin
        if (i == dstall_before) begin
          repeat (dstall_n) begin
            drive(1'b0, 1'($urandom), 1'($urandom));
            step();
          end
        end
        drive(1'b1, d[i], 1'($urandom));
        step();
      end
      if (hold) drive(1'b1, 1'($urandom), 1'($urandom));
      else drive(1'b0, 1'b0, 1'b0);
      span = cyc - t0;
      check("wr_wen", {31'b0, mem_wen}, 32'd1);
      check("wr_addr", {20'b0, mem_addr}, {20'b0, a});
      check("wr_data", {24'b0, mem_wdata}, {24'b0, d});
      check("wr_no_ren", {31'b0, mem_ren}, 32'd0);
      ref_mem[a] = d;
      step();
      check("wr_ready_after", {31'b0, sready}, 32'd1);
      check("wr_wen_once", wen_cnt - wen0, 32'd1);
      check("wr_ren_none", ren_cnt - ren0, 32'd0);
      check("wr_sready_low", low_seen, span + 1);
    end else begin
      if (hold) drive(1'b1, 1'($urandom), 1'($urandom));
      else drive(1'b0, 1'b0, 1'b0);
      span = cyc - t0;
      check("rd_ren", {31'b0, mem_ren}, 32'd1);
      check("rd_addr", {20'b0, mem_addr}, {20'b0, a});
      check("rd_no_wen", {31'b0, mem_wen}, 32'd0);
      step();
      check("rd_gap_valid", {31'b0, ssvalid}, 32'd0);
      check("rd_gap_srdata", {31'b0, srdata}, 32'd0);
      for (int k = 0; k < DW; k++) begin
        if (hold) drive(1'b1, 1'($urandom), 1'($urandom));
        step();
        check("rd_ssvalid", {31'b0, ssvalid}, 32'd1);
        got[k] = srdata;
      end
      if (hold) drive(1'b1, 1'($urandom), 1'($urandom));
      step();
      check("rd_end_valid", {31'b0, ssvalid}, 32'd0);
      check("rd_end_srdata", {31'b0, srdata}, 32'd0);
      check("rd_ready_after", {31'b0, sready}, 32'd1);
      check("rd_ren_once", ren_cnt - ren0, 32'd1);
      check("rd_wen_none", wen_cnt - wen0, 32'd0);
      check("rd_sready_low", low_seen, span + 2 + DW);
      check("rd_value", {24'b0, got}, {24'b0, ref_mem[a]});
    end
  endtask

  initial begin
    int span_a;
    int span_b;
    int wen0;
    int ren0;
    logic [DW-1:0] got;
    logic [AW-1:0] ra;
    bit rw;
    bit hd;

    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));
    rstn = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("rst_sready", {31'b0, sready}, 32'd0);
    check("rst_wen", {31'b0, mem_wen}, 32'd0);
    check("rst_ren", {31'b0, mem_ren}, 32'd0);
    check("rst_ssvalid", {31'b0, ssvalid}, 32'd0);
    check("rst_srdata", {31'b0, srdata}, 32'd0);
    check("rst_addr", {20'b0, mem_addr}, 32'd0);
    check("rst_wdata", {24'b0, mem_wdata}, 32'd0);
    rstn = 1'b1;
    #1;
    check("rst_release_ready", {31'b0, sready}, 32'd1);

    txn(1'b1, 12'h5A3, 8'hC6, -1, 0, -1, 0, 1'b0, span_a, got);
    check("wr_latency", span_a, AW + DW - 1);

    txn(1'b0, 12'h001, 8'h00, -1, 0, -1, 0, 1'b0, span_a, got);
    check("rd_0x001", {24'b0, got}, 32'h81);
    check("rd_latency", span_a, AW - 1);

    txn(1'b1, 12'hFFF, 8'h3C, -1, 0, -1, 0, 1'b0, span_a, got);
    txn(1'b1, 12'hFFF, 8'h3C, 5, 3, 4, 2, 1'b0, span_b, got);
    check("stall_delay", span_b - span_a, 32'd5);
    txn(1'b0, 12'hFFF, 8'h00, -1, 0, -1, 0, 1'b0, span_a, got);
    check("stall_readback", {24'b0, got}, 32'h3C);

    wen0 = wen_cnt;
    ren0 = ren_cnt;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'($urandom), 1'b1);
      step();
    end
    drive(1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check("midrst_ready_low", {31'b0, sready}, 32'd0);
    step();
    check("midrst_ready_edge", {31'b0, sready}, 32'd0);
    check("midrst_wen", {31'b0, mem_wen}, 32'd0);
    check("midrst_ren", {31'b0, mem_ren}, 32'd0);
    rstn = 1'b1;
    #1;
    check("midrst_ready_back", {31'b0, sready}, 32'd1);
    repeat (25) step();
    check("midrst_no_strobes", (wen_cnt - wen0) + (ren_cnt - ren0), 32'd0);
    txn(1'b0, 12'h010, 8'h00, -1, 0, -1, 0, 1'b0, span_a, got);

    txn(1'b0, 12'h5A3, 8'h00, -1, 0, -1, 0, 1'b1, span_a, got);
    check("hold_rd_value", {24'b0, got}, 32'hC6);
    txn(1'b1, 12'h2B7, 8'h5E, -1, 0, -1, 0, 1'b1, span_a, got);
    txn(1'b0, 12'h2B7, 8'h00, -1, 0, -1, 0, 1'b0, span_a, got);
    check("b2b_rd_value", {24'b0, got}, 32'h5E);

    for (int n = 0; n < 40; n++) begin
      ra = {3'($urandom_range(0, 7)), 9'h0A5};
      rw = 1'($urandom);
      hd = (n == 39) ? 1'b0 : 1'($urandom);
      txn(rw, ra, DW'($urandom),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, AW - 1)) : -1,
          int'($urandom_range(1, 4)),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : -1,
          int'($urandom_range(1, 4)),
          hd, span_a, got);
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("final_idle", {31'b0, sready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
